load_store_unit: RTL and testbench

Initiator side of the CPU data-memory interface. Sits between the MEM pipeline stage and a word-addressed, byte-enabled data memory. Accepts one load/store per handshake and drives a request/grant/response bus to memory. Splits word-boundary-crossing accesses into two beats, formats load data (sign/zero extension), and reports illegal funct3 and memory timeouts as errors.

---
 rtl/load_store_unit_if.sv | 36 +++
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - CPU request/response and data-memory bus bundle for the load/store unit
interface load_store_unit_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [2:0]  req_funct3_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  // The load/store unit: target of CPU requests, initiator on the memory bus.
  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_funct3_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  // The surroundings: CPU pipeline plus data memory.
  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_funct3_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit with split word-crossing beats, load formatting and timeout
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.master  bus
);
  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        split_q;
  logic [3:0]  be1_q;
  logic [31:0] wdata1_q;
  logic [31:0] rdata0_q;

  logic [3:0]  mask;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic        legal;

  // Sign/zero extension of the byte-shifted two-word window.
  function automatic logic [31:0] load_fmt(input logic [63:0] pair, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [63:0] s;
    logic [31:0] w;
    s = pair >> {off, 3'b000};
    w = s[31:0];
    case (f3)
      3'd0:    load_fmt = {{24{w[7]}}, w[7:0]};
      3'd4:    load_fmt = {24'h0, w[7:0]};
      3'd1:    load_fmt = {{16{w[15]}}, w[15:0]};
      3'd5:    load_fmt = {16'h0, w[15:0]};
      default: load_fmt = w;
    endcase
  endfunction

  // Decode the incoming request into both beats' lane enables and lane-aligned data.
  always_comb begin
    mask = 4'b0001;
    case (bus.req_funct3_i[1:0])
      2'd1:       mask = 4'b0011;
      2'd2, 2'd3: mask = 4'b1111;
      default:    mask = 4'b0001;
    endcase
    be_wide = {4'b0000, mask} << bus.req_addr_i[1:0];
    wd_wide = {32'h0, bus.req_wdata_i} << {bus.req_addr_i[1:0], 3'b000};
    if (bus.req_we_i)
      legal = bus.req_funct3_i inside {3'd0, 3'd1, 3'd2};
    else
      legal = bus.req_funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  end

  // Access sequencer; every bus and response output is a register set on state transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      we_q              <= 1'b0;
      f3_q              <= '0;
      off_q             <= '0;
      split_q           <= 1'b0;
      be1_q             <= '0;
      wdata1_q          <= '0;
      rdata0_q          <= '0;
      bus.req_ready_o   <= 1'b1;
      bus.resp_valid_o  <= 1'b0;
      bus.resp_rdata_o  <= '0;
      bus.resp_err_o    <= 1'b0;
      bus.mem_req_o     <= 1'b0;
      bus.mem_we_o      <= 1'b0;
      bus.mem_addr_o    <= '0;
      bus.mem_be_o      <= '0;
      bus.mem_wdata_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            bus.req_ready_o <= 1'b0;
            we_q            <= bus.req_we_i;
            f3_q            <= bus.req_funct3_i;
            off_q           <= bus.req_addr_i[1:0];
            split_q         <= |be_wide[7:4];
            be1_q           <= be_wide[7:4];
            wdata1_q        <= wd_wide[63:32];
            if (legal) begin
              state           <= ISSUE0;
              cnt             <= '0;
              bus.mem_req_o   <= 1'b1;
              bus.mem_we_o    <= bus.req_we_i;
              bus.mem_addr_o  <= {bus.req_addr_i[31:2], 2'b00};
              bus.mem_be_o    <= be_wide[3:0];
              bus.mem_wdata_o <= wd_wide[31:0];
            end else begin
              state            <= RESP;
              bus.resp_valid_o <= 1'b1;
              bus.resp_err_o   <= 1'b1;
              bus.resp_rdata_o <= '0;
            end
          end
        end
        ISSUE0, ISSUE1: begin
          if (bus.mem_gnt_i) begin
            bus.mem_req_o <= 1'b0;
            cnt           <= '0;
            if (state == ISSUE0) state <= WAIT0;
            else                 state <= WAIT1;
          end else if (cnt == TO_LAST) begin
            bus.mem_req_o    <= 1'b0;
            state            <= RESP;
            bus.resp_valid_o <= 1'b1;
            bus.resp_err_o   <= 1'b1;
            bus.resp_rdata_o <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT0: begin
          if (bus.mem_rvalid_i) begin
            rdata0_q <= bus.mem_rdata_i;
            if (split_q) begin
              state           <= ISSUE1;
              cnt             <= '0;
              bus.mem_req_o   <= 1'b1;
              bus.mem_addr_o  <= bus.mem_addr_o + 32'd4;
              bus.mem_be_o    <= be1_q;
              bus.mem_wdata_o <= wdata1_q;
            end else begin
              state            <= RESP;
              bus.resp_valid_o <= 1'b1;
              bus.resp_err_o   <= 1'b0;
              bus.resp_rdata_o <= we_q ? 32'h0 : load_fmt({32'h0, bus.mem_rdata_i}, off_q, f3_q);
            end
          end else if (cnt == TO_LAST) begin
            state            <= RESP;
            bus.resp_valid_o <= 1'b1;
            bus.resp_err_o   <= 1'b1;
            bus.resp_rdata_o <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT1: begin
          if (bus.mem_rvalid_i) begin
            state            <= RESP;
            bus.resp_valid_o <= 1'b1;
            bus.resp_err_o   <= 1'b0;
            bus.resp_rdata_o <= we_q ? 32'h0 : load_fmt({bus.mem_rdata_i, rdata0_q}, off_q, f3_q);
          end else if (cnt == TO_LAST) begin
            state            <= RESP;
            bus.resp_valid_o <= 1'b1;
            bus.resp_err_o   <= 1'b1;
            bus.resp_rdata_o <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          bus.resp_valid_o <= 1'b0;
          bus.req_ready_o  <= 1'b1;
          state            <= IDLE;
        end
        default: begin
          state           <= IDLE;
          bus.req_ready_o <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [logic [31:0]];

  int          nbeats;
  int          req_cycles;
  int          resp_cyc;
  logic [31:0] r_data;
  logic        r_err;
  bit          stable_ok;
  logic        ready_seen;
  logic [31:0] b_addr [4];
  logic [3:0]  b_be   [4];
  logic [31:0] b_wd   [4];
  logic        b_we   [4];
  bit          flag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // One CPU access with a simple memory responder; grant after gnt_delay request cycles.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input int gnt_delay, input bit grant);
    bit pend = 0;
    bit prev_req = 0;
    int wait_n = 0;
    logic [31:0] paddr = 32'h0;
    nbeats = 0; req_cycles = 0; resp_cyc = -1; r_data = 'x; r_err = 'x; stable_ok = 1;
    @(negedge clk);
    ready_seen = bus.req_ready_o;
    bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_addr_i = addr;
    bus.req_wdata_i = wd; bus.req_funct3_i = f3;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.req_valid_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
      if (pend) begin
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i = rd(paddr);
        pend = 0;
      end else if (bus.mem_req_o) begin
        req_cycles++;
        if (!prev_req) begin
          if (nbeats < 4) begin
            b_addr[nbeats] = bus.mem_addr_o; b_be[nbeats] = bus.mem_be_o;
            b_wd[nbeats] = bus.mem_wdata_o; b_we[nbeats] = bus.mem_we_o;
          end
          nbeats++;
          wait_n = 0;
        end else if (nbeats >= 1 && nbeats <= 4) begin
          if (bus.mem_addr_o !== b_addr[nbeats-1] || bus.mem_be_o !== b_be[nbeats-1] ||
              bus.mem_wdata_o !== b_wd[nbeats-1] || bus.mem_we_o !== b_we[nbeats-1])
            stable_ok = 0;
        end
        if (grant && wait_n >= gnt_delay) begin
          bus.mem_gnt_i = 1'b1;
          pend = 1;
          paddr = bus.mem_addr_o;
        end
        wait_n++;
      end
      prev_req = bus.mem_req_o;
      if (bus.resp_valid_o) begin
        resp_cyc = c;
        r_data = bus.resp_rdata_o;
        r_err = bus.resp_err_o;
        break;
      end
    end
  endtask

  initial begin
    bus.req_valid_i = 0; bus.req_we_i = 0; bus.req_addr_i = 0; bus.req_wdata_i = 0;
    bus.req_funct3_i = 0; bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
    mem[32'h100] = 32'hDEADBEEF;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, bus.req_ready_o}, 32'd1);
    chk("rst_mem_req", {31'h0, bus.mem_req_o}, 32'd0);
    chk("rst_resp_valid", {31'h0, bus.resp_valid_o}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
    chk("rst_mem_be", {28'h0, bus.mem_be_o}, 32'h0);
    rst_n = 1'b1;

    // Aligned LW
    access(1'b0, 32'h100, 32'h0, 3'd2, 0, 1);
    chk("lw_ready", {31'h0, ready_seen}, 32'd1);
    chk("lw_nbeats", 32'(nbeats), 32'd1);
    chk("lw_addr", b_addr[0], 32'h100);
    chk("lw_be", {28'h0, b_be[0]}, 32'hF);
    chk("lw_we", {31'h0, b_we[0]}, 32'd0);
    chk("lw_cyc", 32'(resp_cyc), 32'd3);
    chk("lw_data", r_data, 32'hDEADBEEF);
    chk("lw_err", {31'h0, r_err}, 32'd0);
    @(negedge clk);
    chk("lw_pulse_one", {31'h0, bus.resp_valid_o}, 32'd0);
    chk("lw_hold", bus.resp_rdata_o, 32'hDEADBEEF);

    // SB at offset 2
    access(1'b1, 32'h202, 32'h000000A5, 3'd0, 0, 1);
    chk("sb_nbeats", 32'(nbeats), 32'd1);
    chk("sb_addr", b_addr[0], 32'h200);
    chk("sb_be", {28'h0, b_be[0]}, 32'b0100);
    chk("sb_wdata", b_wd[0], 32'h00A50000);
    chk("sb_we", {31'h0, b_we[0]}, 32'd1);
    chk("sb_err", {31'h0, r_err}, 32'd0);
    chk("sb_data", r_data, 32'h0);

    // Split LW across 0x100/0x104
    mem[32'h100] = 32'h44332211;
    mem[32'h104] = 32'h88776655;
    access(1'b0, 32'h103, 32'h0, 3'd2, 0, 1);
    chk("slw_ready", {31'h0, ready_seen}, 32'd1);
    chk("slw_nbeats", 32'(nbeats), 32'd2);
    chk("slw_addr0", b_addr[0], 32'h100);
    chk("slw_be0", {28'h0, b_be[0]}, 32'b1000);
    chk("slw_addr1", b_addr[1], 32'h104);
    chk("slw_be1", {28'h0, b_be[1]}, 32'b0111);
    chk("slw_cyc", 32'(resp_cyc), 32'd5);
    chk("slw_data", r_data, 32'h77665544);

    // Extension
    mem[32'h10] = 32'h92348001;
    access(1'b0, 32'h10, 32'h0, 3'd1, 0, 1);
    chk("lh_data", r_data, 32'hFFFF8001);
    access(1'b0, 32'h10, 32'h0, 3'd5, 0, 1);
    chk("lhu_data", r_data, 32'h00008001);
    access(1'b0, 32'h12, 32'h0, 3'd1, 0, 1);
    chk("lh_off2_data", r_data, 32'hFFFF9234);
    access(1'b0, 32'h13, 32'h0, 3'd0, 0, 1);
    chk("lb_data", r_data, 32'hFFFFFF92);
    access(1'b0, 32'h13, 32'h0, 3'd4, 0, 1);
    chk("lbu_data", r_data, 32'h00000092);

    // Wrapping split SW
    access(1'b1, 32'hFFFFFFFE, 32'hAABBCCDD, 3'd2, 0, 1);
    chk("wsw_nbeats", 32'(nbeats), 32'd2);
    chk("wsw_addr0", b_addr[0], 32'hFFFFFFFC);
    chk("wsw_be0", {28'h0, b_be[0]}, 32'b1100);
    chk("wsw_wd0", b_wd[0], 32'hCCDD0000);
    chk("wsw_addr1", b_addr[1], 32'h0);
    chk("wsw_be1", {28'h0, b_be[1]}, 32'b0011);
    chk("wsw_wd1", b_wd[1], 32'h0000AABB);
    chk("wsw_cyc", 32'(resp_cyc), 32'd5);

    // Illegal funct3
    access(1'b1, 32'h40, 32'h1234, 3'd3, 0, 1);
    chk("ill_st_nbeats", 32'(nbeats), 32'd0);
    chk("ill_st_cyc", 32'(resp_cyc), 32'd1);
    chk("ill_st_err", {31'h0, r_err}, 32'd1);
    chk("ill_st_data", r_data, 32'h0);
    access(1'b0, 32'h40, 32'h0, 3'd6, 0, 1);
    chk("ill_ld_nbeats", 32'(nbeats), 32'd0);
    chk("ill_ld_err", {31'h0, r_err}, 32'd1);

    // Grant stall: beat fields held stable
    access(1'b0, 32'h104, 32'h0, 3'd2, 2, 1);
    chk("stall_stable", {31'h0, stable_ok}, 32'd1);
    chk("stall_req_cycles", 32'(req_cycles), 32'd3);
    chk("stall_cyc", 32'(resp_cyc), 32'd5);
    chk("stall_data", r_data, 32'h88776655);

    // Grant timeout, then a stray late rvalid
    access(1'b0, 32'h300, 32'h0, 3'd2, 0, 0);
    chk("to_err", {31'h0, r_err}, 32'd1);
    chk("to_data", r_data, 32'h0);
    chk("to_req_cycles", {31'h0, (req_cycles >= 4 && req_cycles <= 5)}, 32'd1);
    chk("to_nbeats", 32'(nbeats), 32'd1);
    @(negedge clk);
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h55555555;
    flag = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_rvalid_i = 1'b0;
      if (bus.resp_valid_o || bus.mem_req_o || !bus.req_ready_o) flag = 1;
    end
    chk("late_rvalid_ignored", {31'h0, flag}, 32'd0);
    access(1'b0, 32'h100, 32'h0, 3'd2, 0, 1);
    chk("after_to_data", r_data, 32'h44332211);
    chk("after_to_err", {31'h0, r_err}, 32'd0);

    // Reset asserted while in WAIT1
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_addr_i = 32'h103; bus.req_funct3_i = 3'd2;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("rw_issue0", {31'h0, bus.mem_req_o}, 32'd1);
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h44332211;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    chk("rw_issue1_addr", bus.mem_addr_o, 32'h104);
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    bus.mem_gnt_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rw_ready", {31'h0, bus.req_ready_o}, 32'd1);
    chk("rw_mem_req", {31'h0, bus.mem_req_o}, 32'd0);
    chk("rw_mem_addr", bus.mem_addr_o, 32'h0);
    chk("rw_mem_be", {28'h0, bus.mem_be_o}, 32'h0);
    chk("rw_resp_valid", {31'h0, bus.resp_valid_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h88776655;
    flag = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.mem_rvalid_i = 1'b0;
      if (bus.resp_valid_o || bus.mem_req_o) flag = 1;
    end
    chk("rw_no_response", {31'h0, flag}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
